// File: rtl/blackjack_card_dealer_if.sv
// Request/delivery bus between the blackjack game FSM (master) and the card dealer (slave).
interface blackjack_card_dealer_if;
  logic       shuffle;
  logic       card_req;
  logic       busy;
  logic       card_valid;
  logic [7:0] card_value;
  logic [3:0] card_points;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       empty_err;

  modport master (
    output shuffle, card_req,
    input  busy, card_valid, card_value, card_points, cards_left, deck_empty, empty_err
  );

  modport slave (
    input  shuffle, card_req,
    output busy, card_valid, card_value, card_points, cards_left, deck_empty, empty_err
  );
endinterface

// File: rtl/blackjack_card_dealer.sv
// blackjack_card_dealer: 52-card shoe that draws unused cards starting from a free-running LFSR.
// Optional feature macro BJ_AUTO_RESHUFFLE_EN: a request against an empty deck refills it and is served.
module blackjack_card_dealer #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  blackjack_card_dealer_if.slave  dealer_bus
);

  typedef enum logic {READY, PROBE} state_t;

  state_t                state_reg, state_next;
  logic [LFSR_WIDTH-1:0] lfsr_reg;
  logic [5:0]            cand_reg, cand_next;
  logic                  rd_done_reg, rd_done_next;
  logic                  used_bit_reg, used_bit_next;
  logic [51:0]           used_reg, used_next;
  logic [5:0]            cards_left_reg, cards_left_next;
  logic                  card_valid_reg, card_valid_next;
  logic                  empty_err_reg, empty_err_next;
  logic [7:0]            card_value_reg, card_value_next;
  logic [3:0]            card_points_reg, card_points_next;
  logic                  clear_used, set_used;

  logic                  lfsr_fb;
  logic [5:0]            lfsr_low, start_idx, cand_inc;
  logic [1:0]            map_suit;
  logic [3:0]            rank_base, map_rank, map_points;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB
  assign lfsr_fb   = lfsr_reg[LFSR_WIDTH-1] ^ lfsr_reg[LFSR_WIDTH-3] ^
                     lfsr_reg[LFSR_WIDTH-4] ^ lfsr_reg[LFSR_WIDTH-6];
  assign lfsr_low  = lfsr_reg[5:0];
  assign start_idx = (lfsr_low >= 6'd52) ? lfsr_low - 6'd52 : lfsr_low;
  assign cand_inc  = (cand_reg == 6'd51) ? 6'd0 : cand_reg + 6'd1;

  always_comb begin
    map_suit  = 2'd0;
    rank_base = cand_reg[3:0];
    if (cand_reg >= 6'd39) begin
      map_suit  = 2'd3;
      rank_base = 4'(cand_reg - 6'd39);
    end else if (cand_reg >= 6'd26) begin
      map_suit  = 2'd2;
      rank_base = 4'(cand_reg - 6'd26);
    end else if (cand_reg >= 6'd13) begin
      map_suit  = 2'd1;
      rank_base = 4'(cand_reg - 6'd13);
    end
    map_rank   = rank_base + 4'd1;
    map_points = (map_rank >= 4'd10) ? 4'd10 : map_rank;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 52; gi++) begin : g_used
      assign used_next[gi] = clear_used ? 1'b0 :
                             ((set_used && cand_reg == 6'(gi)) ? 1'b1 : used_reg[gi]);
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    cand_next        = cand_reg;
    rd_done_next     = rd_done_reg;
    used_bit_next    = used_bit_reg;
    cards_left_next  = cards_left_reg;
    card_valid_next  = 1'b0;
    empty_err_next   = 1'b0;
    card_value_next  = card_value_reg;
    card_points_next = card_points_reg;
    clear_used       = 1'b0;
    set_used         = 1'b0;

    if (dealer_bus.shuffle) begin
      clear_used      = 1'b1;
      cards_left_next = 6'd52;
      rd_done_next    = 1'b0;
      state_next      = READY;
    end else begin
      case (state_reg)
        READY: begin
          if (dealer_bus.card_req) begin
            if (cards_left_reg != 6'd0) begin
              cand_next    = start_idx;
              rd_done_next = 1'b0;
              state_next   = PROBE;
            end else begin
`ifdef BJ_AUTO_RESHUFFLE_EN
              clear_used      = 1'b1;
              cards_left_next = 6'd52;
              cand_next       = start_idx;
              rd_done_next    = 1'b0;
              state_next      = PROBE;
`else
              empty_err_next  = 1'b1;
`endif
            end
          end
        end
        PROBE: begin
          // First PROBE cycle only performs the registered read of used[cand];
          // later cycles test the read bit and prefetch the next slot on a miss.
          if (!rd_done_reg) begin
            used_bit_next = used_reg[cand_reg];
            rd_done_next  = 1'b1;
          end else if (!used_bit_reg) begin
            set_used         = 1'b1;
            cards_left_next  = cards_left_reg - 6'd1;
            card_valid_next  = 1'b1;
            card_value_next  = {2'b00, map_suit, map_rank};
            card_points_next = map_points;
            rd_done_next     = 1'b0;
            state_next       = READY;
          end else begin
            cand_next     = cand_inc;
            used_bit_next = used_reg[cand_inc];
          end
        end
        default: state_next = READY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= READY;
      lfsr_reg        <= SEED;
      cand_reg        <= 6'd0;
      rd_done_reg     <= 1'b0;
      used_bit_reg    <= 1'b0;
      used_reg        <= '0;
      cards_left_reg  <= 6'd52;
      card_valid_reg  <= 1'b0;
      empty_err_reg   <= 1'b0;
      card_value_reg  <= 8'h00;
      card_points_reg <= 4'd0;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= {lfsr_reg[LFSR_WIDTH-2:0], lfsr_fb};
      cand_reg        <= cand_next;
      rd_done_reg     <= rd_done_next;
      used_bit_reg    <= used_bit_next;
      used_reg        <= used_next;
      cards_left_reg  <= cards_left_next;
      card_valid_reg  <= card_valid_next;
      empty_err_reg   <= empty_err_next;
      card_value_reg  <= card_value_next;
      card_points_reg <= card_points_next;
    end
  end

  assign dealer_bus.busy        = (state_reg != READY);
  assign dealer_bus.card_valid  = card_valid_reg;
  assign dealer_bus.card_value  = card_value_reg;
  assign dealer_bus.card_points = card_points_reg;
  assign dealer_bus.cards_left  = cards_left_reg;
  assign dealer_bus.deck_empty  = (cards_left_reg == 6'd0);
  assign dealer_bus.empty_err   = empty_err_reg;

endmodule
